// File: rtl/waveform_play_scheduler.sv
// waveform_play_scheduler: loads a waveform into the waveform_stream BRAM, then
// replays it as a pulse train on a programmable PRF period, gating the wfout
// stream toward the DAC path and reporting length / timing errors.
module waveform_play_scheduler #(
    parameter int CNT_W    = 16,
    parameter int PERIOD_W = 32
) (
    input  logic                clk_in1,
    input  logic                areset,
    input  logic [31:0]         cfg_wf_len,
    input  logic [PERIOD_W-1:0] cfg_prf_period,
    input  logic [CNT_W-1:0]    cfg_num_pulses,
    input  logic                load_req,
    input  logic                run_req,
    input  logic                stop_req,
    input  logic                wf_write_ready,
    input  logic                wf_read_ready,
    output logic                init_wf_write,
    output logic [127:0]        waveform_parameters,
    input  logic [31:0]         s_axis_tdata,
    input  logic                s_axis_tvalid,
    input  logic                s_axis_tlast,
    output logic                s_axis_tready,
    output logic [31:0]         m_axis_tdata,
    output logic                m_axis_tvalid,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready,
    output logic                busy,
    output logic                loaded,
    output logic                pulse_start,
    output logic [CNT_W-1:0]    pulse_count,
    output logic                err_len,
    output logic                err_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_REQ,
        S_LD_WAIT,
        S_TRIG,
        S_PLAY,
        S_GAP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_wf_len;
    logic [31:0]         r_run_len;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_per_cnt;
    logic [CNT_W-1:0]    r_num_pulses;
    logic [CNT_W-1:0]    r_pulse_count;
    logic [31:0]         r_beat_cnt;
    logic                r_loaded;
    logic                r_seen_low;
    logic                r_stop;
    logic                r_err_len;
    logic                r_err_overrun;

    logic                w_gate;
    logic                w_hs;
    logic                w_expired;
    logic                w_done;
    logic                w_stop_any;
    logic                w_run_start;
    logic                w_reload;
    logic [31:0]         w_beat_next;
    logic                w_unused;

    // The stream starts its BRAM read on tready by itself; its read-ready
    // status carries no extra information for the sequencing here.
    assign w_unused = &{1'b0, wf_read_ready};

    assign w_gate      = (r_state == S_TRIG) || (r_state == S_PLAY);
    assign w_hs        = w_gate && s_axis_tvalid && m_axis_tready;
    assign w_expired   = (r_per_cnt == '0);
    assign w_done      = (r_num_pulses != '0) && (r_pulse_count == r_num_pulses);
    assign w_stop_any  = r_stop || stop_req;
    assign w_beat_next = (r_state == S_TRIG) ? 32'd1 : (r_beat_cnt + 32'd1);

    // Zero-latency gate; data is forced to 0 while closed so idle outputs stay quiet.
    assign m_axis_tvalid = s_axis_tvalid && w_gate;
    assign s_axis_tready = m_axis_tready && w_gate;
    assign m_axis_tdata  = w_gate ? s_axis_tdata : '0;
    assign m_axis_tlast  = w_gate && s_axis_tlast;

    assign waveform_parameters = {96'b0, r_wf_len};
    assign busy                = (r_state != S_IDLE);
    assign loaded              = r_loaded;
    assign pulse_count         = r_pulse_count;
    assign err_len             = r_err_len;
    assign err_overrun         = r_err_overrun;

    // Next-state decode plus the single-cycle strobes that depend on it.
    always_comb begin
        w_next        = r_state;
        init_wf_write = 1'b0;
        pulse_start   = 1'b0;
        w_run_start   = 1'b0;
        w_reload      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_req) begin
                    w_next = S_LD_REQ;
                end else if (run_req && r_loaded) begin
                    w_next      = S_TRIG;
                    w_run_start = 1'b1;
                end
            end
            S_LD_REQ: begin
                if (wf_write_ready) begin
                    init_wf_write = 1'b1;
                    w_next        = S_LD_WAIT;
                end
            end
            S_LD_WAIT: begin
                if (r_seen_low && wf_write_ready) begin
                    w_next = S_IDLE;
                end
            end
            S_TRIG: begin
                if (w_hs) begin
                    pulse_start = 1'b1;
                    w_next      = s_axis_tlast ? S_GAP : S_PLAY;
                end else if (stop_req) begin
                    w_next = S_IDLE;
                end
            end
            S_PLAY: begin
                if (w_hs && s_axis_tlast) begin
                    w_next = S_GAP;
                end
            end
            S_GAP: begin
                if (w_stop_any || w_done) begin
                    w_next = S_IDLE;
                end else if (w_expired) begin
                    w_next   = S_TRIG;
                    w_reload = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register and all run bookkeeping: latches, counters, sticky errors.
    always_ff @(posedge clk_in1 or posedge areset) begin
        if (areset) begin
            r_state       <= S_IDLE;
            r_wf_len      <= '0;
            r_run_len     <= '0;
            r_period      <= '0;
            r_per_cnt     <= '0;
            r_num_pulses  <= '0;
            r_pulse_count <= '0;
            r_beat_cnt    <= '0;
            r_loaded      <= 1'b0;
            r_seen_low    <= 1'b0;
            r_stop        <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (load_req) begin
                        r_wf_len <= cfg_wf_len;
                    end else if (w_run_start) begin
                        r_period      <= (cfg_prf_period == '0) ? PERIOD_W'(1) : cfg_prf_period;
                        r_num_pulses  <= cfg_num_pulses;
                        r_run_len     <= cfg_wf_len;
                        r_pulse_count <= '0;
                        r_err_len     <= 1'b0;
                        r_err_overrun <= 1'b0;
                        r_stop        <= 1'b0;
                    end
                end
                S_LD_REQ: begin
                    if (wf_write_ready) begin
                        r_loaded   <= 1'b0;
                        r_seen_low <= 1'b0;
                    end
                end
                S_LD_WAIT: begin
                    if (!wf_write_ready) begin
                        r_seen_low <= 1'b1;
                    end else if (r_seen_low) begin
                        r_loaded <= 1'b1;
                    end
                end
                S_TRIG, S_PLAY: begin
                    if (w_expired) begin
                        r_err_overrun <= 1'b1;
                    end
                    // Once a beat has gone out the packet is committed; stop only ends the run after it.
                    if (stop_req && ((r_state == S_PLAY) || w_hs)) begin
                        r_stop <= 1'b1;
                    end
                    if (w_hs) begin
                        r_beat_cnt <= w_beat_next;
                        if (s_axis_tlast) begin
                            if (w_beat_next != r_run_len) begin
                                r_err_len <= 1'b1;
                            end
                            if (r_pulse_count != '1) begin
                                r_pulse_count <= r_pulse_count + CNT_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase

            // PRF counter counts start-to-start; it parks at 0 once expired.
            if (w_run_start) begin
                r_per_cnt <= (cfg_prf_period == '0) ? '0 : (cfg_prf_period - PERIOD_W'(1));
            end else if (w_reload) begin
                r_per_cnt <= r_period - PERIOD_W'(1);
            end else if (!w_expired) begin
                r_per_cnt <= r_per_cnt - PERIOD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_waveform_play_scheduler.sv
// Directed bench for waveform_play_scheduler with a simple waveform_stream source model.
module tb_waveform_play_scheduler;

    logic         clk_in1;
    logic         areset;
    logic [31:0]  cfg_wf_len;
    logic [31:0]  cfg_prf_period;
    logic [15:0]  cfg_num_pulses;
    logic         load_req, run_req, stop_req;
    logic         wf_write_ready, wf_read_ready;
    logic         init_wf_write;
    logic [127:0] waveform_parameters;
    logic [31:0]  s_axis_tdata;
    logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic         busy, loaded, pulse_start;
    logic [15:0]  pulse_count;
    logic         err_len, err_overrun;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Source model: endless packets of src_len beats, data = {C0DE, beat index}.
    logic        src_en;
    logic [15:0] src_len;
    logic [15:0] src_idx;

    int ob_ps, ob_beats, ob_last, ob_derr, ob_diff0, ob_diff1;
    bit ob_timeout;

    waveform_play_scheduler #(.CNT_W(16), .PERIOD_W(32)) dut (
        .clk_in1(clk_in1), .areset(areset),
        .cfg_wf_len(cfg_wf_len), .cfg_prf_period(cfg_prf_period), .cfg_num_pulses(cfg_num_pulses),
        .load_req(load_req), .run_req(run_req), .stop_req(stop_req),
        .wf_write_ready(wf_write_ready), .wf_read_ready(wf_read_ready),
        .init_wf_write(init_wf_write), .waveform_parameters(waveform_parameters),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .busy(busy), .loaded(loaded), .pulse_start(pulse_start), .pulse_count(pulse_count),
        .err_len(err_len), .err_overrun(err_overrun)
    );

    initial clk_in1 = 1'b0;
    always #5 clk_in1 = ~clk_in1;

    always @(posedge clk_in1) cyc <= cyc + 1;

    assign s_axis_tvalid = src_en;
    assign s_axis_tdata  = {16'hC0DE, src_idx};
    assign s_axis_tlast  = ((src_idx + 16'd1) == src_len);

    always @(posedge clk_in1 or posedge areset) begin
        if (areset) src_idx <= '0;
        else if (s_axis_tvalid && s_axis_tready) src_idx <= s_axis_tlast ? 16'd0 : src_idx + 16'd1;
    end

    task automatic strobe_run();
        @(negedge clk_in1); run_req = 1'b1;
        @(negedge clk_in1); run_req = 1'b0;
    endtask

    // Runs until busy drops or the budget expires, collecting pulse and beat statistics.
    task automatic observe_run(input int budget, input int stop_after, input bit rnd);
        int prev_cyc;
        int exp_idx;
        bit stopped;
        ob_ps = 0; ob_beats = 0; ob_last = 0; ob_derr = 0; ob_diff0 = -1; ob_diff1 = -1;
        ob_timeout = 1'b1; prev_cyc = 0; exp_idx = 0; stopped = 1'b0;
        for (int c = 0; c < budget; c++) begin
            m_axis_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            stop_req = (stop_after > 0) && !stopped && (ob_beats >= stop_after);
            if (stop_req) stopped = 1'b1;
            #1;
            if (!busy) begin
                ob_timeout = 1'b0;
                break;
            end
            if (pulse_start) begin
                if (ob_ps == 1) ob_diff0 = cyc - prev_cyc;
                if (ob_ps == 2) ob_diff1 = cyc - prev_cyc;
                prev_cyc = cyc;
                ob_ps++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                ob_beats++;
                if (m_axis_tdata !== {16'hC0DE, exp_idx[15:0]}) ob_derr++;
                if (m_axis_tlast) begin
                    ob_last++;
                    exp_idx = 0;
                end else begin
                    exp_idx++;
                end
            end
            @(negedge clk_in1);
        end
        stop_req = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    // Walks the BRAM-write handshake: ready high, low for 5 cycles, then high again.
    task automatic load_handshake(output int n_init, output bit mid_loaded, output bit saw_gate);
        n_init = 0; mid_loaded = 1'b1; saw_gate = 1'b0;
        for (int c = 0; c < 12; c++) begin
            wf_write_ready = !(c >= 2 && c < 7);
            #1;
            if (init_wf_write) n_init++;
            if (c == 4) mid_loaded = loaded;
            if (pulse_start || s_axis_tready) saw_gate = 1'b1;
            @(negedge clk_in1);
        end
        wf_write_ready = 1'b1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge clk_in1);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b want=0", busy); end
        n_vec++; if (loaded !== 1'b0) begin n_err++; $display("FAIL reset_loaded got=%0b want=0", loaded); end
        n_vec++; if (waveform_parameters !== 128'd0) begin n_err++; $display("FAIL reset_params got=%0h want=0", waveform_parameters); end
        n_vec++; if ({m_axis_tvalid, m_axis_tlast, s_axis_tready, m_axis_tdata} !== 35'd0) begin n_err++; $display("FAIL reset_axis got=%0h want=0", {m_axis_tvalid, m_axis_tlast, s_axis_tready, m_axis_tdata}); end
        n_vec++; if ({init_wf_write, pulse_start, err_len, err_overrun, pulse_count} !== 20'd0) begin n_err++; $display("FAIL reset_misc got=%0h want=0", {init_wf_write, pulse_start, err_len, err_overrun, pulse_count}); end
        @(negedge clk_in1); areset = 1'b0;
    endtask

    task automatic test_load();
        int  n_init;
        bit  mid_loaded, saw_gate;
        cfg_wf_len = 32'd128; wf_write_ready = 1'b1;
        @(negedge clk_in1); load_req = 1'b1;
        @(negedge clk_in1); load_req = 1'b0;
        load_handshake(n_init, mid_loaded, saw_gate);
        #1;
        n_vec++; if (n_init !== 1) begin n_err++; $display("FAIL load_init_count got=%0d want=1", n_init); end
        n_vec++; if (mid_loaded !== 1'b0) begin n_err++; $display("FAIL load_mid_loaded got=%0b want=0", mid_loaded); end
        n_vec++; if (loaded !== 1'b1) begin n_err++; $display("FAIL load_done got=%0b want=1", loaded); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL load_idle got=%0b want=0", busy); end
        n_vec++; if (waveform_parameters !== 128'd128) begin n_err++; $display("FAIL load_params got=%0h want=80", waveform_parameters); end
    endtask

    task automatic test_run();
        cfg_num_pulses = 16'd3; cfg_prf_period = 32'd1000; src_len = 16'd128;
        strobe_run();
        observe_run(3000, 0, 1'b0);
        n_vec++; if (ob_timeout !== 1'b0) begin n_err++; $display("FAIL run_timeout got=1 want=0"); end
        n_vec++; if (ob_ps !== 3) begin n_err++; $display("FAIL run_pulses got=%0d want=3", ob_ps); end
        n_vec++; if (ob_diff0 !== 1000 || ob_diff1 !== 1000) begin n_err++; $display("FAIL run_spacing got=%0d,%0d want=1000,1000", ob_diff0, ob_diff1); end
        n_vec++; if (ob_beats !== 384 || ob_last !== 3) begin n_err++; $display("FAIL run_beats got=%0d/%0d want=384/3", ob_beats, ob_last); end
        n_vec++; if (ob_derr !== 0) begin n_err++; $display("FAIL run_data got=%0d want=0", ob_derr); end
        n_vec++; if (pulse_count !== 16'd3) begin n_err++; $display("FAIL run_count got=%0d want=3", pulse_count); end
        n_vec++; if ({err_len, err_overrun} !== 2'b00) begin n_err++; $display("FAIL run_errs got=%0b want=00", {err_len, err_overrun}); end
    endtask

    task automatic test_len_err();
        cfg_num_pulses = 16'd2; cfg_prf_period = 32'd300; src_len = 16'd100;
        strobe_run();
        observe_run(2000, 0, 1'b0);
        src_len = 16'd128;
        n_vec++; if (ob_timeout !== 1'b0) begin n_err++; $display("FAIL len_timeout got=1 want=0"); end
        n_vec++; if (err_len !== 1'b1) begin n_err++; $display("FAIL len_err got=%0b want=1", err_len); end
        n_vec++; if (err_overrun !== 1'b0) begin n_err++; $display("FAIL len_overrun got=%0b want=0", err_overrun); end
        n_vec++; if (ob_ps !== 2 || ob_beats !== 200 || ob_diff0 !== 300) begin n_err++; $display("FAIL len_run got=%0d/%0d/%0d want=2/200/300", ob_ps, ob_beats, ob_diff0); end
        n_vec++; if (pulse_count !== 16'd2) begin n_err++; $display("FAIL len_count got=%0d want=2", pulse_count); end
    endtask

    task automatic test_overrun();
        cfg_num_pulses = 16'd3; cfg_prf_period = 32'd50;
        strobe_run();
        observe_run(2000, 0, 1'b0);
        n_vec++; if (ob_timeout !== 1'b0) begin n_err++; $display("FAIL ovr_timeout got=1 want=0"); end
        n_vec++; if (err_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag got=%0b want=1", err_overrun); end
        n_vec++; if (err_len !== 1'b0) begin n_err++; $display("FAIL ovr_len_cleared got=%0b want=0", err_len); end
        n_vec++; if (ob_diff0 !== 129 || ob_diff1 !== 129) begin n_err++; $display("FAIL ovr_spacing got=%0d,%0d want=129,129", ob_diff0, ob_diff1); end
        n_vec++; if (ob_beats !== 384 || ob_derr !== 0) begin n_err++; $display("FAIL ovr_beats got=%0d/%0d want=384/0", ob_beats, ob_derr); end
    endtask

    task automatic test_stop_backpressure();
        cfg_num_pulses = 16'd0; cfg_prf_period = 32'd200;
        strobe_run();
        observe_run(3000, 200, 1'b1);
        n_vec++; if (ob_timeout !== 1'b0) begin n_err++; $display("FAIL stop_timeout got=1 want=0"); end
        n_vec++; if (ob_ps !== 2 || ob_last !== 2) begin n_err++; $display("FAIL stop_pulses got=%0d/%0d want=2/2", ob_ps, ob_last); end
        n_vec++; if (ob_beats !== 256 || ob_derr !== 0) begin n_err++; $display("FAIL stop_beats got=%0d/%0d want=256/0", ob_beats, ob_derr); end
        n_vec++; if (pulse_count !== 16'd2 || err_len !== 1'b0) begin n_err++; $display("FAIL stop_count got=%0d/%0b want=2/0", pulse_count, err_len); end
    endtask

    task automatic test_priority();
        int  n_init;
        bit  mid_loaded, saw_gate;
        cfg_wf_len = 32'd96; wf_write_ready = 1'b1;
        @(negedge clk_in1); load_req = 1'b1; run_req = 1'b1;
        @(negedge clk_in1); load_req = 1'b0; run_req = 1'b0;
        load_handshake(n_init, mid_loaded, saw_gate);
        #1;
        n_vec++; if (n_init !== 1) begin n_err++; $display("FAIL prio_init got=%0d want=1", n_init); end
        n_vec++; if (saw_gate !== 1'b0) begin n_err++; $display("FAIL prio_no_run got=%0b want=0", saw_gate); end
        n_vec++; if (mid_loaded !== 1'b0 || loaded !== 1'b1) begin n_err++; $display("FAIL prio_loaded got=%0b,%0b want=0,1", mid_loaded, loaded); end
        n_vec++; if (waveform_parameters !== 128'd96 || pulse_count !== 16'd2) begin n_err++; $display("FAIL prio_state got=%0h/%0d want=60/2", waveform_parameters, pulse_count); end
        cfg_wf_len = 32'd128;
    endtask

    task automatic test_stop_trig();
        src_en = 1'b0; cfg_num_pulses = 16'd5; cfg_prf_period = 32'd100;
        strobe_run();
        #1;
        n_vec++; if (busy !== 1'b1 || s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL trig_hold got=%0b%0b%0b want=110", busy, s_axis_tready, m_axis_tvalid); end
        @(negedge clk_in1); @(negedge clk_in1);
        stop_req = 1'b1;
        @(negedge clk_in1); stop_req = 1'b0; src_en = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0 || pulse_count !== 16'd0) begin n_err++; $display("FAIL trig_stop got=%0b/%0d want=0/0", busy, pulse_count); end
        n_vec++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin n_err++; $display("FAIL trig_gate_closed got=%0b%0b want=00", m_axis_tvalid, s_axis_tready); end
    endtask

    task automatic test_areset_mid_play();
        cfg_num_pulses = 16'd0; cfg_prf_period = 32'd140;
        strobe_run();
        repeat (150) @(negedge clk_in1);
        #1;
        n_vec++; if (busy !== 1'b1 || m_axis_tvalid !== 1'b1 || pulse_count !== 16'd1) begin n_err++; $display("FAIL ares_pre got=%0b%0b/%0d want=11/1", busy, m_axis_tvalid, pulse_count); end
        areset = 1'b1;
        #1;
        n_vec++; if ({busy, loaded, init_wf_write, pulse_start, err_len, err_overrun} !== 6'd0) begin n_err++; $display("FAIL ares_ctrl got=%0b want=000000", {busy, loaded, init_wf_write, pulse_start, err_len, err_overrun}); end
        n_vec++; if ({m_axis_tvalid, m_axis_tlast, s_axis_tready, m_axis_tdata} !== 35'd0) begin n_err++; $display("FAIL ares_axis got=%0h want=0", {m_axis_tvalid, m_axis_tlast, s_axis_tready, m_axis_tdata}); end
        n_vec++; if (pulse_count !== 16'd0 || waveform_parameters !== 128'd0) begin n_err++; $display("FAIL ares_regs got=%0d/%0h want=0/0", pulse_count, waveform_parameters); end
        @(negedge clk_in1); @(negedge clk_in1); areset = 1'b0;
        strobe_run();
        #1;
        n_vec++; if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL ares_run_unloaded got=%0b%0b want=00", busy, m_axis_tvalid); end
    endtask

    initial begin
        areset = 1'b1; cfg_wf_len = 32'd128; cfg_prf_period = 32'd1000; cfg_num_pulses = 16'd0;
        load_req = 1'b0; run_req = 1'b0; stop_req = 1'b0;
        wf_write_ready = 1'b1; wf_read_ready = 1'b1; m_axis_tready = 1'b1;
        src_en = 1'b1; src_len = 16'd128;
        test_reset();
        test_load();
        test_run();
        test_len_err();
        test_overrun();
        test_stop_backpressure();
        test_priority();
        test_stop_trig();
        test_areset_mid_play();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
